fft_power_avg: RTL

FFT_POWER_AVG -- requirements
Module: fft_power_avg

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_mag_sq.sv | 32 +++
 rtl/fft_power_avg.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types for the FFT power-averaging path: complex bin layout and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package fft_pkg;

  // Component width of the default complex bin layout.
  localparam int CPLX_W = 16;

  // One FFT bin as it arrives on the bus: re in the upper half, both signed.
  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } complex_t;

  // ACCUM: sum incoming frames into the per-bin accumulators.
  // DRAIN: stream the averaged bins out, one per output transfer.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/fft_mag_sq.sv
// Squared magnitude of one complex bin: re*re + im*im, exact and unsigned.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state.
module fft_mag_sq #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [2*DATA_WIDTH-1:0] cplx_i,
  output logic [2*DATA_WIDTH-1:0] pwr_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [DATA_WIDTH-1:0] re;
  logic signed [DATA_WIDTH-1:0] im;
  logic signed [PW-1:0]         re_ext;
  logic signed [PW-1:0]         im_ext;
  logic signed [PW-1:0]         re_sq;
  logic signed [PW-1:0]         im_sq;

  // Each square is at most 2^(PW-2), so the PW-bit signed product is exact and
  // non-negative; the unsigned sum peaks at 2^(PW-1) and cannot overflow PW bits.
  always_comb begin
    re     = cplx_i[PW-1:DATA_WIDTH];
    im     = cplx_i[DATA_WIDTH-1:0];
    re_ext = PW'(re);
    im_ext = PW'(im);
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
    pwr_o  = $unsigned(re_sq) + $unsigned(im_sq);
  end

endmodule

// File: rtl/fft_power_avg.sv
// Averages bin power over 2^AVG_LOG2 FFT frames, then streams the averaged frame out.
// Latency: averaged frame starts the cycle after the last input bin; one bin per output transfer.
// Backpressure: input always accepted in ACCUM, never in DRAIN; output holds while pwr_ready_i low.
module fft_power_avg
  import fft_pkg::*;
#(
  parameter int FFT_SIZE   = 1024,
  parameter int DATA_WIDTH = 16,
  parameter int AVG_LOG2   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [2*DATA_WIDTH-1:0] fft_data_i,
  input  logic                    fft_valid_i,
  output logic                    fft_ready_o,
  output logic [2*DATA_WIDTH-1:0] pwr_data_o,
  output logic                    pwr_valid_o,
  input  logic                    pwr_ready_i,
  output logic                    pwr_last_o
);

  localparam int PW         = 2 * DATA_WIDTH;
  localparam int ACC_W      = PW + AVG_LOG2;
  localparam int BIN_W      = $clog2(FFT_SIZE);
  localparam int FRAME_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int NUM_FRAMES = 1 << AVG_LOG2;

  localparam logic [BIN_W-1:0]   BIN_LAST   = BIN_W'(FFT_SIZE - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;

  logic [PW-1:0]       power;
  logic [ACC_W-1:0]    acc_mem [FFT_SIZE];
  logic [ACC_W-1:0]    acc_rd;
  logic [ACC_W-1:0]    acc_wr;
  logic                acc_we;
  logic                in_xfer;
  logic                out_xfer;
  logic                bin_is_last;

  fft_mag_sq #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mag_sq (
    .cplx_i (fft_data_i),
    .pwr_o  (power)
  );

  // Outputs depend only on registered state and the array read, never on the handshake inputs.
  always_comb begin
    bin_is_last = (bin_q == BIN_LAST);
    acc_rd      = acc_mem[bin_q];
    fft_ready_o = (state_q == ST_ACCUM);
    pwr_valid_o = (state_q == ST_DRAIN);
    pwr_last_o  = pwr_valid_o && bin_is_last;
    pwr_data_o  = pwr_valid_o ? acc_rd[AVG_LOG2 +: PW] : '0;
    in_xfer     = fft_valid_i && fft_ready_o;
    out_xfer    = pwr_valid_o && pwr_ready_i;
  end

  // First frame overwrites so stale contents after reset never leak into a result.
  always_comb begin
    acc_we = in_xfer;
    acc_wr = (frame_q == '0) ? ACC_W'(power) : acc_rd + ACC_W'(power);
  end

  // Next-state logic: bin/frame counters advance only on transfers.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    frame_d = frame_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_xfer) begin
          bin_d = bin_q + BIN_W'(1);
          if (bin_is_last) begin
            bin_d = '0;
            if (frame_q == FRAME_LAST) begin
              frame_d = '0;
              state_d = ST_DRAIN;
            end else begin
              frame_d = frame_q + FRAME_W'(1);
            end
          end
        end
      end
      ST_DRAIN: begin
        if (out_xfer) begin
          bin_d = bin_q + BIN_W'(1);
          if (bin_is_last) begin
            bin_d   = '0;
            state_d = ST_ACCUM;
          end
        end
      end
      default: begin
        state_d = ST_ACCUM;
        bin_d   = '0;
        frame_d = '0;
      end
    endcase
  end

  // Control registers; reset discards any partial frame or drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ACCUM;
      bin_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      frame_q <= frame_d;
    end
  end

  // Accumulator array: single index, one read and one write per cycle, no reset so it maps to RAM.
  always_ff @(posedge clk_i) begin
    if (acc_we) begin
      acc_mem[bin_q] <= acc_wr;
    end
  end

endmodule
